fir_xifu_ctrl: RTL and testbench

Pipeline controller for the FIR XIFU (ID -> EX -> WB). Tracks every offloaded instruction by its X-interface id from issue to retire, and absorbs the core's commit/kill stream. Produces the per-id commit vector consumed by EX (store gating), the EX/WB ready/stall signal, and the pipeline clear used on kills. Also bounds outstanding LSU transactions issued through the coprocessor memory interface.

---
 rtl/fir_xifu_ctrl_pkg.sv | 21 ++
 rtl/fir_xifu_ctrl_if.sv | 44 ++++
 rtl/fir_xifu_ctrl_idtable.sv | 82 ++++++++
 rtl/fir_xifu_ctrl.sv | 91 +++++++++
 tb/tb_fir_xifu_ctrl.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fir_xifu_ctrl_pkg.sv
// Shared types for the FIR XIFU pipeline controller: per-id tracking states
// and the control bundle handed from the controller to the EX stage.
package fir_xifu_ctrl_pkg;

  localparam int NUM_ID_DEF          = 4;
  localparam int MAX_OUTSTANDING_DEF = 2;

  typedef enum logic [1:0] {
    ID_FREE      = 2'd0,
    ID_ISSUED    = 2'd1,
    ID_COMMITTED = 2'd2,
    ID_KILLED    = 2'd3
  } id_state_e;

  typedef struct packed {
    logic [NUM_ID_DEF-1:0] commit;
    logic                  ready;
    logic                  clear;
  } ctrl2ex_t;

endpackage

// File: rtl/fir_xifu_ctrl_if.sv
// Issue/commit/EX/WB/memory signals between the XIFU pipeline (master) and
// its controller (slave).
interface fir_xifu_ctrl_if #(
  parameter int NUM_ID          = 4,
  parameter int MAX_OUTSTANDING = 2
);
  localparam int ID_W  = (NUM_ID > 1) ? $clog2(NUM_ID) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic              issue_valid_i;
  logic [ID_W-1:0]   issue_id_i;
  logic              issue_ready_o;
  logic              commit_valid_i;
  logic [ID_W-1:0]   commit_id_i;
  logic              commit_kill_i;
  logic              ex_valid_i;
  logic [ID_W-1:0]   ex_id_i;
  logic              ex_is_store_i;
  logic              ex_is_load_i;
  logic              mem_ready_i;
  logic              mem_result_valid_i;
  logic              wb_retire_i;
  logic [ID_W-1:0]   wb_id_i;
  logic [NUM_ID-1:0] commit_o;
  logic              ex_ready_o;
  logic              clear_o;
  logic [CNT_W-1:0]  outstanding_o;
  logic              err_o;

  modport master (
    output issue_valid_i, issue_id_i, commit_valid_i, commit_id_i, commit_kill_i,
           ex_valid_i, ex_id_i, ex_is_store_i, ex_is_load_i, mem_ready_i,
           mem_result_valid_i, wb_retire_i, wb_id_i,
    input  issue_ready_o, commit_o, ex_ready_o, clear_o, outstanding_o, err_o
  );

  modport slave (
    input  issue_valid_i, issue_id_i, commit_valid_i, commit_id_i, commit_kill_i,
           ex_valid_i, ex_id_i, ex_is_store_i, ex_is_load_i, mem_ready_i,
           mem_result_valid_i, wb_retire_i, wb_id_i,
    output issue_ready_o, commit_o, ex_ready_o, clear_o, outstanding_o, err_o
  );

endinterface

// File: rtl/fir_xifu_ctrl_idtable.sv
// Per-id lifecycle table (FREE/ISSUED/COMMITTED/KILLED) with the zero-latency
// commit bypass and kill detection for the instruction currently in EX.
module fir_xifu_ctrl_idtable
  import fir_xifu_ctrl_pkg::*;
#(
  parameter  int NUM_ID = NUM_ID_DEF,
  localparam int ID_W   = (NUM_ID > 1) ? $clog2(NUM_ID) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_valid,
  input  logic [ID_W-1:0]   issue_id,
  input  logic              commit_valid,
  input  logic [ID_W-1:0]   commit_id,
  input  logic              commit_kill,
  input  logic              ex_valid,
  input  logic [ID_W-1:0]   ex_id,
  input  logic              wb_retire,
  input  logic [ID_W-1:0]   wb_id,
  output logic [NUM_ID-1:0] commit_vec,
  output logic              issue_free,
  output logic              clear,
  output logic              issue_err,
  output logic              commit_err
);

  id_state_e state_q [NUM_ID];
  id_state_e state_d [NUM_ID];

  logic retire_ok;
  logic commit_ok;
  logic issue_acc;

  always_comb begin
    retire_ok  = wb_retire & (state_q[wb_id] == ID_COMMITTED);
    // A retire frees its entry before a same-cycle issue to that id is judged.
    issue_free = (state_q[issue_id] == ID_FREE) | (retire_ok & (wb_id == issue_id));
    commit_ok  = commit_valid & (state_q[commit_id] == ID_ISSUED);
    clear      = ex_valid & ((state_q[ex_id] == ID_KILLED) |
                             (commit_ok & commit_kill & (commit_id == ex_id)));
    issue_acc  = issue_valid & issue_free & ~clear;
    issue_err  = issue_valid & ~issue_free;
    commit_err = commit_valid & ~commit_ok;

    for (int i = 0; i < NUM_ID; i++) begin
      commit_vec[i] = (state_q[i] == ID_COMMITTED) |
                      (commit_valid & ~commit_kill & (commit_id == ID_W'(i)));
    end

    for (int i = 0; i < NUM_ID; i++) begin
      state_d[i] = state_q[i];
      if (clear && (ex_id == ID_W'(i))) begin
        state_d[i] = ID_FREE;
      end else begin
        unique case (state_q[i])
          ID_FREE: begin
            if (issue_acc && (issue_id == ID_W'(i))) state_d[i] = ID_ISSUED;
          end
          ID_ISSUED: begin
            if (commit_ok && (commit_id == ID_W'(i)))
              state_d[i] = commit_kill ? ID_KILLED : ID_COMMITTED;
          end
          ID_COMMITTED: begin
            if (retire_ok && (wb_id == ID_W'(i)))
              state_d[i] = (issue_acc && (issue_id == ID_W'(i))) ? ID_ISSUED : ID_FREE;
          end
          // A killed id that never reached EX is released one cycle later.
          ID_KILLED: state_d[i] = ID_FREE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ID; i++) state_q[i] <= ID_FREE;
    end else begin
      for (int i = 0; i < NUM_ID; i++) state_q[i] <= state_d[i];
    end
  end

endmodule

// File: rtl/fir_xifu_ctrl.sv
// FIR XIFU pipeline controller: id tracking, EX stall/clear generation and
// the bound on outstanding LSU requests.
module fir_xifu_ctrl
  import fir_xifu_ctrl_pkg::*;
#(
  parameter int NUM_ID          = NUM_ID_DEF,
  parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF
) (
  input logic             clk_i,
  input logic             rst_ni,
  fir_xifu_ctrl_if.slave  xif
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [NUM_ID-1:0] commit_vec;
  logic              issue_free;
  logic              clear;
  logic              issue_err;
  logic              commit_err;
  logic              mem_op;
  logic              mem_hs;
  logic              res_err;
  logic              ex_ready;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic              err_q;
  logic              err_d;
  ctrl2ex_t          ctrl2ex;

  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt,
                                                input logic inc, input logic dec);
    if (inc && !dec) return cnt + CNT_W'(1);
    if (dec && !inc && (cnt != '0)) return cnt - CNT_W'(1);
    return cnt;
  endfunction

  fir_xifu_ctrl_idtable #(.NUM_ID(NUM_ID)) u_idtable (
    .clk          (clk_i),
    .rst_n        (rst_ni),
    .issue_valid  (xif.issue_valid_i),
    .issue_id     (xif.issue_id_i),
    .commit_valid (xif.commit_valid_i),
    .commit_id    (xif.commit_id_i),
    .commit_kill  (xif.commit_kill_i),
    .ex_valid     (xif.ex_valid_i),
    .ex_id        (xif.ex_id_i),
    .wb_retire    (xif.wb_retire_i),
    .wb_id        (xif.wb_id_i),
    .commit_vec   (commit_vec),
    .issue_free   (issue_free),
    .clear        (clear),
    .issue_err    (issue_err),
    .commit_err   (commit_err)
  );

  always_comb begin
    // Stores go to memory only once committed; killed instructions never do.
    mem_op   = xif.ex_valid_i &
               (xif.ex_is_load_i | (xif.ex_is_store_i & commit_vec[xif.ex_id_i]));
    mem_hs   = mem_op & xif.mem_ready_i & (cnt_q < CNT_W'(MAX_OUTSTANDING)) & ~clear;
    ex_ready = 1'b1;
    if (xif.ex_valid_i && !clear && (xif.ex_is_load_i || xif.ex_is_store_i) && !mem_hs)
      ex_ready = 1'b0;
    res_err  = xif.mem_result_valid_i & (cnt_q == '0);
    cnt_d    = cnt_next(cnt_q, mem_hs, xif.mem_result_valid_i);
    err_d    = err_q | issue_err | commit_err | res_err;

    ctrl2ex.commit = NUM_ID_DEF'(commit_vec);
    ctrl2ex.ready  = ex_ready;
    ctrl2ex.clear  = clear;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign xif.issue_ready_o = issue_free & ~clear;
  assign xif.commit_o      = NUM_ID'(ctrl2ex.commit);
  assign xif.ex_ready_o    = ctrl2ex.ready;
  assign xif.clear_o       = ctrl2ex.clear;
  assign xif.outstanding_o = cnt_q;
  assign xif.err_o         = err_q;

endmodule

// File: tb/tb_fir_xifu_ctrl.sv
// Scenario tests plus a randomized run against an instruction-record model.
module tb_fir_xifu_ctrl;

  localparam int NID  = 4;
  localparam int MAXO = 2;

  logic clk;
  logic rst_ni;
  int   total;
  int   bad;

  fir_xifu_ctrl_if #(.NUM_ID(NID), .MAX_OUTSTANDING(MAXO)) xif ();

  fir_xifu_ctrl #(.NUM_ID(NID), .MAX_OUTSTANDING(MAXO)) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .xif    (xif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle();
    xif.issue_valid_i      = 1'b0;
    xif.issue_id_i         = '0;
    xif.commit_valid_i     = 1'b0;
    xif.commit_id_i        = '0;
    xif.commit_kill_i      = 1'b0;
    xif.ex_valid_i         = 1'b0;
    xif.ex_id_i            = '0;
    xif.ex_is_store_i      = 1'b0;
    xif.ex_is_load_i       = 1'b0;
    xif.mem_ready_i        = 1'b0;
    xif.mem_result_valid_i = 1'b0;
    xif.wb_retire_i        = 1'b0;
    xif.wb_id_i            = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    #1;
  endtask

  task automatic issue(input int id);
    idle();
    xif.issue_valid_i = 1'b1;
    xif.issue_id_i    = 2'(id);
    tick();
    idle();
  endtask

  task automatic test_reset();
    idle();
    rst_ni = 1'b0;
    #3;
    total++; if (xif.commit_o !== 4'b0000) begin bad++; $display("FAIL reset_commit: got %b want 0000", xif.commit_o); end
    total++; if (xif.clear_o !== 1'b0) begin bad++; $display("FAIL reset_clear: got %b want 0", xif.clear_o); end
    total++; if (xif.ex_ready_o !== 1'b1) begin bad++; $display("FAIL reset_ex_ready: got %b want 1", xif.ex_ready_o); end
    total++; if (xif.issue_ready_o !== 1'b1) begin bad++; $display("FAIL reset_issue_ready: got %b want 1", xif.issue_ready_o); end
    total++; if (xif.outstanding_o !== 2'd0) begin bad++; $display("FAIL reset_outstanding: got %0d want 0", xif.outstanding_o); end
    total++; if (xif.err_o !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", xif.err_o); end
    tick();
    rst_ni = 1'b1;
    #1;
  endtask

  task automatic test_load();
    do_reset();
    xif.issue_valid_i = 1'b1; xif.issue_id_i = 2'd1; #1;
    total++; if (xif.issue_ready_o !== 1'b1) begin bad++; $display("FAIL load_issue_ready: got %b want 1", xif.issue_ready_o); end
    tick(); idle();
    xif.ex_valid_i = 1'b1; xif.ex_id_i = 2'd1; xif.ex_is_load_i = 1'b1; xif.mem_ready_i = 1'b1; #1;
    total++; if (xif.ex_ready_o !== 1'b1) begin bad++; $display("FAIL load_ex_ready: got %b want 1", xif.ex_ready_o); end
    tick(); idle(); #1;
    total++; if (xif.outstanding_o !== 2'd1) begin bad++; $display("FAIL load_outstanding_inc: got %0d want 1", xif.outstanding_o); end
    xif.mem_result_valid_i = 1'b1;
    tick(); idle(); #1;
    total++; if (xif.outstanding_o !== 2'd0) begin bad++; $display("FAIL load_outstanding_dec: got %0d want 0", xif.outstanding_o); end
    total++; if (xif.err_o !== 1'b0) begin bad++; $display("FAIL load_err: got %b want 0", xif.err_o); end
  endtask

  task automatic test_store_commit_same();
    do_reset();
    issue(2);
    xif.ex_valid_i = 1'b1; xif.ex_id_i = 2'd2; xif.ex_is_store_i = 1'b1; xif.mem_ready_i = 1'b1;
    xif.commit_valid_i = 1'b1; xif.commit_id_i = 2'd2; #1;
    total++; if (xif.commit_o !== 4'b0100) begin bad++; $display("FAIL store_same_commit: got %b want 0100", xif.commit_o); end
    total++; if (xif.ex_ready_o !== 1'b1) begin bad++; $display("FAIL store_same_ex_ready: got %b want 1", xif.ex_ready_o); end
    tick(); idle(); #1;
    total++; if (xif.outstanding_o !== 2'd1) begin bad++; $display("FAIL store_same_outstanding: got %0d want 1", xif.outstanding_o); end
    total++; if (xif.commit_o !== 4'b0100) begin bad++; $display("FAIL store_same_commit_held: got %b want 0100", xif.commit_o); end
  endtask

  task automatic test_store_commit_late();
    do_reset();
    issue(2);
    for (int c = 0; c < 3; c++) begin
      xif.ex_valid_i = 1'b1; xif.ex_id_i = 2'd2; xif.ex_is_store_i = 1'b1; xif.mem_ready_i = 1'b1; #1;
      total++; if (xif.ex_ready_o !== 1'b0) begin bad++; $display("FAIL store_late_stall%0d: got %b want 0", c, xif.ex_ready_o); end
      tick();
    end
    xif.commit_valid_i = 1'b1; xif.commit_id_i = 2'd2; #1;
    total++; if (xif.ex_ready_o !== 1'b1) begin bad++; $display("FAIL store_late_release: got %b want 1", xif.ex_ready_o); end
    tick(); idle(); #1;
    total++; if (xif.outstanding_o !== 2'd1) begin bad++; $display("FAIL store_late_outstanding: got %0d want 1", xif.outstanding_o); end
  endtask

  task automatic test_kill();
    do_reset();
    issue(3);
    xif.ex_valid_i = 1'b1; xif.ex_id_i = 2'd3; xif.ex_is_load_i = 1'b1; xif.mem_ready_i = 1'b1;
    xif.commit_valid_i = 1'b1; xif.commit_id_i = 2'd3; xif.commit_kill_i = 1'b1; #1;
    total++; if (xif.clear_o !== 1'b1) begin bad++; $display("FAIL kill_clear: got %b want 1", xif.clear_o); end
    total++; if (xif.ex_ready_o !== 1'b1) begin bad++; $display("FAIL kill_ex_ready: got %b want 1", xif.ex_ready_o); end
    total++; if (xif.commit_o !== 4'b0000) begin bad++; $display("FAIL kill_commit: got %b want 0000", xif.commit_o); end
    tick(); idle(); xif.issue_id_i = 2'd3; #1;
    total++; if (xif.clear_o !== 1'b0) begin bad++; $display("FAIL kill_clear_one_cycle: got %b want 0", xif.clear_o); end
    total++; if (xif.outstanding_o !== 2'd0) begin bad++; $display("FAIL kill_no_mem: got %0d want 0", xif.outstanding_o); end
    total++; if (xif.issue_ready_o !== 1'b1) begin bad++; $display("FAIL kill_reissue_ready: got %b want 1", xif.issue_ready_o); end
    issue(3);
    xif.commit_valid_i = 1'b1; xif.commit_id_i = 2'd3; xif.commit_kill_i = 1'b1;
    tick(); idle(); xif.issue_id_i = 2'd3; #1;
    total++; if (xif.issue_ready_o !== 1'b0) begin bad++; $display("FAIL kill_pending_busy: got %b want 0", xif.issue_ready_o); end
    tick(); #1;
    total++; if (xif.issue_ready_o !== 1'b1) begin bad++; $display("FAIL kill_released: got %b want 1", xif.issue_ready_o); end
    total++; if (xif.err_o !== 1'b0) begin bad++; $display("FAIL kill_err: got %b want 0", xif.err_o); end
  endtask

  task automatic test_max_outstanding();
    do_reset();
    issue(0);
    issue(1);
    for (int k = 0; k < 2; k++) begin
      xif.ex_valid_i = 1'b1; xif.ex_id_i = 2'(k); xif.ex_is_load_i = 1'b1; xif.mem_ready_i = 1'b1; #1;
      total++; if (xif.ex_ready_o !== 1'b1) begin bad++; $display("FAIL max_load%0d_ready: got %b want 1", k, xif.ex_ready_o); end
      tick();
    end
    total++; if (xif.outstanding_o !== 2'd2) begin bad++; $display("FAIL max_count: got %0d want 2", xif.outstanding_o); end
    xif.ex_id_i = 2'd0; #1;
    for (int c = 0; c < 2; c++) begin
      total++; if (xif.ex_ready_o !== 1'b0) begin bad++; $display("FAIL max_stall%0d: got %b want 0", c, xif.ex_ready_o); end
      tick();
    end
    xif.mem_result_valid_i = 1'b1; #1;
    total++; if (xif.ex_ready_o !== 1'b0) begin bad++; $display("FAIL max_stall_on_result: got %b want 0", xif.ex_ready_o); end
    tick(); xif.mem_result_valid_i = 1'b0; #1;
    total++; if (xif.ex_ready_o !== 1'b1) begin bad++; $display("FAIL max_release: got %b want 1", xif.ex_ready_o); end
    tick(); idle(); #1;
    total++; if (xif.outstanding_o !== 2'd2) begin bad++; $display("FAIL max_count_after: got %0d want 2", xif.outstanding_o); end
  endtask

  task automatic test_retire_issue();
    do_reset();
    issue(0);
    xif.commit_valid_i = 1'b1; xif.commit_id_i = 2'd0;
    tick(); idle();
    xif.wb_retire_i = 1'b1; xif.wb_id_i = 2'd0; xif.issue_valid_i = 1'b1; xif.issue_id_i = 2'd0; #1;
    total++; if (xif.issue_ready_o !== 1'b1) begin bad++; $display("FAIL ri_issue_ready: got %b want 1", xif.issue_ready_o); end
    tick(); idle(); #1;
    total++; if (xif.err_o !== 1'b0) begin bad++; $display("FAIL ri_err: got %b want 0", xif.err_o); end
    total++; if (xif.commit_o !== 4'b0000) begin bad++; $display("FAIL ri_commit: got %b want 0000", xif.commit_o); end
    total++; if (xif.issue_ready_o !== 1'b0) begin bad++; $display("FAIL ri_busy: got %b want 0", xif.issue_ready_o); end
    xif.commit_valid_i = 1'b1; xif.commit_id_i = 2'd0;
    tick(); idle(); #1;
    total++; if (xif.commit_o !== 4'b0001) begin bad++; $display("FAIL ri_recommit: got %b want 0001", xif.commit_o); end
    total++; if (xif.err_o !== 1'b0) begin bad++; $display("FAIL ri_recommit_err: got %b want 0", xif.err_o); end
  endtask

  task automatic test_errors();
    do_reset();
    xif.commit_valid_i = 1'b1; xif.commit_id_i = 2'd1;
    tick(); idle(); #1;
    total++; if (xif.err_o !== 1'b1) begin bad++; $display("FAIL err_commit_free: got %b want 1", xif.err_o); end
    total++; if (xif.commit_o !== 4'b0000) begin bad++; $display("FAIL err_commit_ignored: got %b want 0000", xif.commit_o); end
    do_reset();
    total++; if (xif.err_o !== 1'b0) begin bad++; $display("FAIL err_reset1: got %b want 0", xif.err_o); end
    xif.mem_result_valid_i = 1'b1;
    tick(); idle(); #1;
    total++; if (xif.err_o !== 1'b1) begin bad++; $display("FAIL err_result_zero: got %b want 1", xif.err_o); end
    total++; if (xif.outstanding_o !== 2'd0) begin bad++; $display("FAIL err_count_stays: got %0d want 0", xif.outstanding_o); end
    tick(); #1;
    total++; if (xif.err_o !== 1'b1) begin bad++; $display("FAIL err_sticky: got %b want 1", xif.err_o); end
    do_reset();
    total++; if (xif.err_o !== 1'b0) begin bad++; $display("FAIL err_reset2: got %b want 0", xif.err_o); end
    total++; if (xif.commit_o !== 4'b0000) begin bad++; $display("FAIL err_reset_commit: got %b want 0000", xif.commit_o); end
  endtask

  // Model: one record per id holding whether an instruction is in flight and
  // whether the core has committed or killed it.
  task automatic test_random(input int cycles);
    bit live[NID], cmt[NID], kil[NID];
    bit nlive[NID], ncmt[NID], nkil[NID];
    int outst;
    bit err;
    int iv, iid, cv, cid, ck, ev, eid, op, mr, rv, wr, wid;
    bit eclr, freefor, acc, memop, hs, eready;
    logic [NID-1:0] ecommit;
    do_reset();
    for (int i = 0; i < NID; i++) begin live[i] = 0; cmt[i] = 0; kil[i] = 0; end
    outst = 0; err = 0;
    for (int n = 0; n < cycles; n++) begin
      total++; if (xif.outstanding_o !== 2'(outst)) begin bad++; $display("FAIL rnd_outstanding @%0d: got %0d want %0d", n, xif.outstanding_o, outst); end
      total++; if (xif.err_o !== err) begin bad++; $display("FAIL rnd_err @%0d: got %b want %b", n, xif.err_o, err); end
      iv = ($urandom_range(0, 2) == 0); iid = $urandom_range(0, NID-1);
      cv = ($urandom_range(0, 2) == 0); cid = $urandom_range(0, NID-1); ck = ($urandom_range(0, 3) == 0);
      ev = $urandom_range(0, 1); eid = $urandom_range(0, NID-1); op = $urandom_range(0, 2);
      mr = ($urandom_range(0, 3) != 0); rv = ($urandom_range(0, 3) == 0);
      wr = ($urandom_range(0, 2) == 0); wid = $urandom_range(0, NID-1);
      // Keep the protocol mostly legal so the error flag does not saturate early.
      if (iv && live[iid]) iv = 0;
      if (cv && (!live[cid] || cmt[cid] || kil[cid])) cv = ($urandom_range(0, 15) == 0);
      if (rv && outst == 0) rv = ($urandom_range(0, 15) == 0);
      xif.issue_valid_i = iv[0]; xif.issue_id_i = 2'(iid);
      xif.commit_valid_i = cv[0]; xif.commit_id_i = 2'(cid); xif.commit_kill_i = ck[0];
      xif.ex_valid_i = ev[0]; xif.ex_id_i = 2'(eid);
      xif.ex_is_load_i = (op == 1); xif.ex_is_store_i = (op == 2);
      xif.mem_ready_i = mr[0]; xif.mem_result_valid_i = rv[0];
      xif.wb_retire_i = wr[0]; xif.wb_id_i = 2'(wid);
      #1;
      eclr = ev && (kil[eid] || (cv && ck && cid == eid && live[cid] && !cmt[cid] && !kil[cid]));
      freefor = !live[iid] || (wr && cmt[wid] && wid == iid);
      acc = iv && freefor && !eclr;
      for (int i = 0; i < NID; i++) ecommit[i] = cmt[i] || (cv && !ck && cid == i);
      memop = ev && (op == 1 || (op == 2 && ecommit[eid]));
      hs = memop && mr && (outst < MAXO) && !eclr;
      eready = eclr || !ev || op == 0 || hs;
      total++; if (xif.clear_o !== eclr) begin bad++; $display("FAIL rnd_clear @%0d: got %b want %b", n, xif.clear_o, eclr); end
      total++; if (xif.issue_ready_o !== (freefor && !eclr)) begin bad++; $display("FAIL rnd_issue_ready @%0d: got %b want %b", n, xif.issue_ready_o, freefor && !eclr); end
      total++; if (xif.commit_o !== ecommit) begin bad++; $display("FAIL rnd_commit @%0d: got %b want %b", n, xif.commit_o, ecommit); end
      total++; if (xif.ex_ready_o !== eready) begin bad++; $display("FAIL rnd_ex_ready @%0d: got %b want %b", n, xif.ex_ready_o, eready); end
      if (iv && !freefor) err = 1;
      if (cv && !(live[cid] && !cmt[cid] && !kil[cid])) err = 1;
      if (rv && outst == 0) err = 1;
      if (hs && !rv) outst++;
      else if (rv && !hs && outst > 0) outst--;
      for (int i = 0; i < NID; i++) begin
        nlive[i] = live[i]; ncmt[i] = cmt[i]; nkil[i] = kil[i];
        if ((eclr && eid == i) || kil[i]) begin
          nlive[i] = 0; ncmt[i] = 0; nkil[i] = 0;
        end else if (cmt[i]) begin
          if (wr && wid == i) begin
            ncmt[i] = 0; nlive[i] = (acc && iid == i);
          end
        end else if (live[i]) begin
          if (cv && cid == i) begin
            if (ck) nkil[i] = 1; else ncmt[i] = 1;
          end
        end else if (acc && iid == i) begin
          nlive[i] = 1;
        end
      end
      for (int i = 0; i < NID; i++) begin live[i] = nlive[i]; cmt[i] = ncmt[i]; kil[i] = nkil[i]; end
      tick();
    end
    idle();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    idle();
    rst_ni = 1'b1;
    #2;
    test_reset();
    test_load();
    test_store_commit_same();
    test_store_commit_late();
    test_kill();
    test_max_outstanding();
    test_retire_issue();
    test_errors();
    test_random(600);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
